// File: rtl/timer_ctl.sv
// Programmable down-counter timer with a byte-wide register interface.
// Supports one-shot and periodic modes, a sticky terminal flag, and a coherent high-byte snapshot.
module timer_ctl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic       MasterClock,
  input  logic       reset,
  input  logic       wr,
  input  logic       rd,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       tick,
  output logic       irq,
  output logic       running
);

  localparam int unsigned HiW = CNT_W - 8;
  localparam logic [CNT_W-1:0] CntOne = 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StCount = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic [HiW-1:0]   snap_q, snap_d;
  logic             en_q, en_d;
  logic             per_q, per_d;
  logic             ie_q, ie_d;
  logic             flag_q, flag_d;

  logic ctrl_wr, cmd_wr, terminal;

  assign ctrl_wr  = wr && (addr == 2'd2);
  assign cmd_wr   = wr && (addr == 2'd3);
  assign terminal = (state_q == StCount) && tick && (count_q == '0);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    snap_d   = snap_q;
    en_d     = en_q;
    per_d    = per_q;
    ie_d     = ie_q;
    flag_d   = flag_q;

    if (wr && (addr == 2'd0)) reload_d[7:0] = din;
    if (wr && (addr == 2'd1)) reload_d[CNT_W-1:8] = din[HiW-1:0];
    // Latching the high byte on a low-byte read keeps a low-then-high read pair coherent.
    if (rd && (addr == 2'd0)) snap_d = count_q[CNT_W-1:8];

    unique case (state_q)
      StLoad: begin
        count_d = reload_q;
        state_d = StCount;
      end
      StCount: begin
        if (tick) begin
          if (count_q != '0) begin
            count_d = count_q - CntOne;
          end else if (per_q) begin
            count_d = reload_q;
          end else begin
            state_d = StStop;
            en_d    = 1'b0;
          end
        end
      end
      default: ;
    endcase

    if (cmd_wr && din[1] && (state_q == StCount)) count_d = reload_q;
    if (cmd_wr && din[0]) flag_d = 1'b0;
    if (terminal) flag_d = 1'b1;

    // Control writes win over the FSM; EN=1 while already enabled only retunes mode bits.
    if (ctrl_wr) begin
      per_d = din[1];
      ie_d  = din[2];
      if (!din[0]) begin
        en_d    = 1'b0;
        state_d = StIdle;
        count_d = count_q;
      end else if (!en_q) begin
        en_d    = 1'b1;
        state_d = StLoad;
      end
    end
  end

  always_ff @(posedge MasterClock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      snap_q   <= '0;
      en_q     <= 1'b0;
      per_q    <= 1'b0;
      ie_q     <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      snap_q   <= snap_d;
      en_q     <= en_d;
      per_q    <= per_d;
      ie_q     <= ie_d;
      flag_q   <= flag_d;
    end
  end

  assign irq     = flag_q && ie_q;
  assign running = (state_q == StLoad) || (state_q == StCount);

  always_comb begin
    dout = 8'h00;
    unique case (addr)
      2'd0: dout = count_q[7:0];
      2'd1: dout[HiW-1:0] = snap_q;
      2'd2: dout = {4'b0000, flag_q, ie_q, per_q, en_q};
      default: dout = 8'h00;
    endcase
  end

endmodule
